uart_rx_fifo_core: RTL
======================

// Module: uart_rx_fifo_core
// PURPOSE
//  Parametrised UART receiver with an integrated show-ahead RX FIFO. Sits beside the transmit path
//  in the UART top level, in place of the fixed 7/8-bit receiver and 256x8 FIFO pair.
//  Adds: runtime 5..DATA_W data bits, 1 or 2 stop bits, per-entry parity/framing flags,
//  break detect, sticky overflow and an idle-timeout flag.
// PARAMETERS
//  DATA_W     9   max data bits per character (5..9); FIFO entry = DATA_W+2 bits
//  OVS        16  oversampling ticks per bit (even, >=4)
//  FIFO_DEPTH 16  RX FIFO entries (power of 2, >=2)
//  BAUD_W     13  width of BAUD_VAL
//  TO_BITS    32  idle bit-times before RX_TIMEOUT asserts (>=1)
// PORTS
//  CLK          in   1           system clock
//  RESET_N      in   1           asynchronous active-low reset
//  BAUD_VAL     in   BAUD_W      tick divider: one oversample tick every BAUD_VAL+1 CLK cycles
//  DATA_BITS    in   4           data bits per char; values <5 treated as 5, >DATA_W as DATA_W
//  PARITY_EN    in   1           1 = parity bit follows data
//  ODD_N_EVEN   in   1           1 = odd parity, 0 = even
//  STOP2        in   1           1 = two stop bits checked
//  RX           in   1           serial input (asynchronous)
//  RD_EN        in   1           pop FIFO head (ignored when empty)
//  CLR_OVERFLOW in   1           clears OVERFLOW
//  DATA_OUT     out  DATA_W      FIFO head data, right-justified, unused MSBs 0
//  PERR_OUT     out  1           parity error flag of FIFO head
//  FERR_OUT     out  1           framing error flag of FIFO head
//  RXRDY        out  1           FIFO non-empty
//  FIFO_LEVEL   out  log2(D)+1   number of valid entries, 0..FIFO_DEPTH
//  OVERFLOW     out  1           sticky: a character was dropped
//  BREAK_DET    out  1           one-CLK pulse on break character
//  RX_TIMEOUT   out  1           sticky idle-timeout with data pending
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; FIFO empty; RX synchroniser flops reset to 1.
//  Tick gen: counter 0..BAUD_VAL, tick when count==BAUD_VAL then reload 0; BAUD_VAL=0 -> tick every CLK.
//  RX passes a 2-flop synchroniser; all decisions use the synchronised value.
//  FSM (advances on ticks only; DATA_BITS/PARITY_EN/STOP2 latched on start-bit detect):
//   IDLE   : rx==0 on a tick -> START, sample counter cleared.
//   START  : at tick OVS/2-1 rx==1 -> IDLE (false start, nothing written); else counter restarts -> DATA.
//   DATA   : sample every OVS ticks, LSB first; after DATA_BITS samples -> PARITY if enabled else STOP.
//   PARITY : one sample; perr = (XOR(data,bit) != ODD_N_EVEN).
//   STOP   : 1 or 2 samples; ferr = any stop sample 0. Write strobe on the CLK of the last stop sample,
//            then IDLE immediately (a start bit directly after the last stop mid-point is accepted).
//  Break: data, parity (if enabled) and first stop sample all 0 -> BREAK_DET pulses with the write strobe;
//   entry written as data 0, ferr=1.
//  FIFO: show-ahead; written entry visible on DATA_OUT/RXRDY/FIFO_LEVEL the CLK after the strobe.
//   RD_EN pops head on the same edge; outputs show next entry (or 0 when empty) the following cycle.
//   Write when full: accepted only if RD_EN pops that cycle (level stays FIFO_DEPTH); otherwise the
//   char is dropped, FIFO unchanged, OVERFLOW set. Read and write when empty: write accepted, RD_EN ignored.
//   Pointers wrap modulo FIFO_DEPTH; FIFO_LEVEL never exceeds FIFO_DEPTH.
//  OVERFLOW: set on drop, cleared by CLR_OVERFLOW; simultaneous set and clear -> stays 1.
//  Timeout: bit-time counter (OVS ticks) runs while FSM IDLE and RXRDY=1; cleared by RD_EN,
//   start-bit detect or FIFO empty. Reaching TO_BITS sets RX_TIMEOUT; cleared by RD_EN or start-bit detect.
//  Reset mid-character: character discarded, FIFO emptied, all flags cleared.
// TESTING
//  1 8N1, BAUD_VAL=0, OVS=16, send 0xA5 -> one entry 0xA5, PERR/FERR 0, RXRDY 1, FIFO_LEVEL 1.
//  2 7 data, odd parity, STOP2, send 0x41 with bad parity then 2nd stop bit 0 -> head 0x41, PERR=1, FERR=1.
//  3 Send FIFO_DEPTH+1 chars without RD_EN -> FIFO_LEVEL 16, OVERFLOW 1, 17th char lost, first 16 read in order.
//  4 Full FIFO, RD_EN coinciding with write strobe -> level stays 16, no OVERFLOW, new char at tail.
//  5 RX held low 12 bit-times in 8N1 -> one entry data 0 FERR 1, single BREAK_DET pulse.
//  6 One char then idle 32 bit-times -> RX_TIMEOUT 1; RD_EN clears it; RESET_N low mid-char -> all 0.

Source files
------------

// File: rtl/uart_rx_fifo_core.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_core
//   UART receiver with an integrated show-ahead RX FIFO. It supports a runtime
//   character format of 5..DATA_W data bits, optional parity, and 1 or 2 stop
//   bits. Each FIFO entry carries parity and framing flags. The block also
//   reports break characters, a sticky overflow and an idle timeout.
//
// Ports
//   CLK, RESET_N        system clock, asynchronous active-low reset
//   BAUD_VAL            one oversample tick every BAUD_VAL+1 CLK cycles
//   DATA_BITS           data bits per char (clamped to 5..DATA_W)
//   PARITY_EN           1 = a parity bit follows the data bits
//   ODD_N_EVEN          1 = odd parity, 0 = even parity
//   STOP2               1 = check two stop bits
//   RX                  asynchronous serial input
//   RD_EN               pop the FIFO head
//   CLR_OVERFLOW        clear OVERFLOW
//   DATA_OUT            head data, right-justified (0 when empty)
//   PERR_OUT, FERR_OUT  parity and framing flags of the head entry
//   RXRDY, FIFO_LEVEL   FIFO non-empty, number of valid entries
//   OVERFLOW            sticky: a character was dropped
//   BREAK_DET           one-CLK pulse when a break character is written
//   RX_TIMEOUT          sticky: line idle TO_BITS bit-times with data pending
//
// Read handshake: RXRDY acts as "valid" and RD_EN acts as "ready". A pop occurs
// on a rising CLK edge where both are 1. RD_EN is ignored while RXRDY is 0. The
// next entry (or all zeros when empty) appears on the cycle after the pop.
// -----------------------------------------------------------------------------
module uart_rx_fifo_core #(
   parameter int DATA_W     = 9,
   parameter int OVS        = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int BAUD_W     = 13,
   parameter int TO_BITS    = 32
) (
   input  logic                          CLK,
   input  logic                          RESET_N,
   input  logic [BAUD_W-1:0]             BAUD_VAL,
   input  logic [3:0]                    DATA_BITS,
   input  logic                          PARITY_EN,
   input  logic                          ODD_N_EVEN,
   input  logic                          STOP2,
   input  logic                          RX,
   input  logic                          RD_EN,
   input  logic                          CLR_OVERFLOW,
   output logic [DATA_W-1:0]             DATA_OUT,
   output logic                          PERR_OUT,
   output logic                          FERR_OUT,
   output logic                          RXRDY,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
   output logic                          OVERFLOW,
   output logic                          BREAK_DET,
   output logic                          RX_TIMEOUT
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(OVS);
   localparam int TW = $clog2(TO_BITS + 1);
   localparam int EW = DATA_W + 2;

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

   // ---------------- oversample tick ----------------
   logic [BAUD_W-1:0] baud_cnt;
   logic              tick;

   // ">=" gives the same result as "==" while BAUD_VAL is stable. It also avoids
   // a long wrap-around when BAUD_VAL is lowered below the running count.
   assign tick = (baud_cnt >= BAUD_VAL);

   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) baud_cnt <= '0;
      else          baud_cnt <= tick ? '0 : baud_cnt + 1'b1;

   // ---------------- RX synchroniser ----------------
   logic rx_s1, rx_sync;

   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         rx_s1   <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_s1   <= RX;
         rx_sync <= rx_s1;
      end

   // ---------------- receive FSM ----------------
   state_t            state, state_nxt;
   logic [CW-1:0]     smp_cnt, smp_cnt_nxt;
   logic [3:0]        bit_cnt, bit_cnt_nxt;
   logic [DATA_W-1:0] shreg, shreg_nxt;
   logic              par_bit, par_bit_nxt;
   logic              ferr_acc, ferr_acc_nxt;
   logic              stop1_bad, stop1_bad_nxt;
   logic [3:0]        cfg_nbits, dbits_eff;
   logic              cfg_par, cfg_odd, cfg_stop2;
   logic              wait_high;
   logic              start_det, wr_stb, samp, half;
   logic              perr_w, ferr_w, brk_w;
   logic [EW-1:0]     wr_entry;

   always_comb begin
      dbits_eff = DATA_BITS;
      if (DATA_BITS < 4'd5)                dbits_eff = 4'd5;
      else if (DATA_BITS > 4'(DATA_W))     dbits_eff = 4'(DATA_W);
   end

   assign samp = tick && (smp_cnt == CW'(OVS - 1));
   assign half = tick && (smp_cnt == CW'(OVS / 2 - 1));

   // Entry fields include the stop sample that is taken in the current cycle.
   assign ferr_w = ferr_acc | ~rx_sync;
   assign perr_w = cfg_par & ((^shreg ^ par_bit) != cfg_odd);
   // A break has all data zero, no parity 1 and a low first stop bit. The shift
   // register already holds zero in that case, so the entry data is 0 and ferr=1.
   assign brk_w  = (shreg == '0) && !(cfg_par && par_bit) &&
                   ((bit_cnt == 4'd0) ? ~rx_sync : stop1_bad);
   assign wr_entry  = {ferr_w, perr_w, shreg};
   assign BREAK_DET = wr_stb & brk_w;

   always_comb begin
      state_nxt     = state;
      smp_cnt_nxt   = smp_cnt;
      bit_cnt_nxt   = bit_cnt;
      shreg_nxt     = shreg;
      par_bit_nxt   = par_bit;
      ferr_acc_nxt  = ferr_acc;
      stop1_bad_nxt = stop1_bad;
      start_det     = 1'b0;
      wr_stb        = 1'b0;
      case (state)
         ST_IDLE:
            // After a break the line must return high before a new start
            // bit is accepted. This stops a held-low line from producing
            // further characters.
            if (tick && !rx_sync && !wait_high) begin
               start_det     = 1'b1;
               state_nxt     = ST_START;
               smp_cnt_nxt   = '0;
               bit_cnt_nxt   = '0;
               shreg_nxt     = '0;
               par_bit_nxt   = 1'b0;
               ferr_acc_nxt  = 1'b0;
               stop1_bad_nxt = 1'b0;
            end
         ST_START:
            if (half) begin
               smp_cnt_nxt = '0;
               state_nxt   = rx_sync ? ST_IDLE : ST_DATA;
            end else if (tick) begin
               smp_cnt_nxt = smp_cnt + 1'b1;
            end
         ST_DATA:
            if (samp) begin
               smp_cnt_nxt = '0;
               shreg_nxt   = shreg | (DATA_W'(rx_sync) << bit_cnt);
               if (bit_cnt == cfg_nbits - 4'd1) begin
                  bit_cnt_nxt = '0;
                  state_nxt   = cfg_par ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end
            end else if (tick) begin
               smp_cnt_nxt = smp_cnt + 1'b1;
            end
         ST_PARITY:
            if (samp) begin
               smp_cnt_nxt = '0;
               par_bit_nxt = rx_sync;
               state_nxt   = ST_STOP;
            end else if (tick) begin
               smp_cnt_nxt = smp_cnt + 1'b1;
            end
         ST_STOP:
            if (samp) begin
               smp_cnt_nxt  = '0;
               ferr_acc_nxt = ferr_w;
               if (bit_cnt == 4'd0) stop1_bad_nxt = ~rx_sync;
               if (cfg_stop2 && bit_cnt == 4'd0) begin
                  bit_cnt_nxt = 4'd1;
               end else begin
                  wr_stb    = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end else if (tick) begin
               smp_cnt_nxt = smp_cnt + 1'b1;
            end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         state     <= ST_IDLE;
         smp_cnt   <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         ferr_acc  <= 1'b0;
         stop1_bad <= 1'b0;
         cfg_nbits <= 4'd8;
         cfg_par   <= 1'b0;
         cfg_odd   <= 1'b0;
         cfg_stop2 <= 1'b0;
         wait_high <= 1'b0;
      end else begin
         state     <= state_nxt;
         smp_cnt   <= smp_cnt_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shreg     <= shreg_nxt;
         par_bit   <= par_bit_nxt;
         ferr_acc  <= ferr_acc_nxt;
         stop1_bad <= stop1_bad_nxt;
         if (start_det) begin
            cfg_nbits <= dbits_eff;
            cfg_par   <= PARITY_EN;
            cfg_odd   <= ODD_N_EVEN;
            cfg_stop2 <= STOP2;
         end
         if (wr_stb && brk_w) wait_high <= 1'b1;
         else if (rx_sync)    wait_high <= 1'b0;
      end

   // ---------------- show-ahead FIFO ----------------
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   level;
   logic          empty, full, do_rd, do_wr, drop;
   logic [EW-1:0] head;

   assign empty = (level == '0);
   assign full  = (level == (AW+1)'(FIFO_DEPTH));
   assign do_rd = RD_EN & ~empty;
   // When the FIFO is full, a write is accepted only if a pop frees a slot on the same edge.
   assign do_wr = wr_stb & (~full | do_rd);
   assign drop  = wr_stb & full & ~do_rd;

   always_ff @(posedge CLK)
      if (do_wr) mem[wr_ptr] <= wr_entry;

   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end

   assign head       = mem[rd_ptr];
   assign DATA_OUT   = empty ? '0 : head[DATA_W-1:0];
   assign PERR_OUT   = ~empty & head[DATA_W];
   assign FERR_OUT   = ~empty & head[DATA_W+1];
   assign RXRDY      = ~empty;
   assign FIFO_LEVEL = level;

   // ---------------- overflow and idle timeout ----------------
   logic [CW-1:0] to_sub;
   logic [TW-1:0] to_bits;
   logic          to_clr;

   assign to_clr = RD_EN | start_det | empty;

   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         OVERFLOW   <= 1'b0;
         RX_TIMEOUT <= 1'b0;
         to_sub     <= '0;
         to_bits    <= '0;
      end else begin
         if (drop)              OVERFLOW <= 1'b1;
         else if (CLR_OVERFLOW) OVERFLOW <= 1'b0;

         if (to_clr) begin
            to_sub  <= '0;
            to_bits <= '0;
         end else if (state == ST_IDLE && tick) begin
            if (to_sub == CW'(OVS - 1)) begin
               to_sub <= '0;
               if (to_bits != TW'(TO_BITS)) to_bits <= to_bits + 1'b1;
            end else begin
               to_sub <= to_sub + 1'b1;
            end
         end

         if (RD_EN || start_det)          RX_TIMEOUT <= 1'b0;
         else if (to_bits == TW'(TO_BITS)) RX_TIMEOUT <= 1'b1;
      end

endmodule
